// File: rtl/decrypt_mac_engine.sv
// Iterative ROUNDS-round block decryptor with valid/ready handshakes and a running
// per-message MAC that is checked against the supplied tag on the last block.
module decrypt_mac_engine #(
    parameter int unsigned N      = 8,
    parameter int unsigned ROUNDS = 4
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_key_i,
    input  logic [N-1:0] in_data_i,
    input  logic         in_last_i,
    input  logic [N-1:0] in_tag_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_data_o,
    output logic         out_last_o,
    output logic [N-1:0] out_mac_o,
    output logic         out_mac_ok_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [N-1:0] LastRound = N'(ROUNDS - 1);
    localparam logic [N-1:0] One       = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1]};
    endfunction

    function automatic logic [N-1:0] rotr1(input logic [N-1:0] x);
        return {x[0], x[N-1:1]};
    endfunction

    function automatic logic [N-1:0] round_key(input logic [N-1:0] key,
                                               input logic [N-1:0] r);
        int unsigned  amt;
        logic [N-1:0] rot;
        amt = 32'(r) % N;
        rot = key;
        for (int unsigned i = 0; i < N; i++) begin
            if (i < amt) rot = rotl1(rot);
        end
        return rot ^ r;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [N-1:0] s_q, s_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] key_q, key_d;
    logic [N-1:0] mac_q, mac_d;
    logic [N-1:0] tag_q, tag_d;
    logic [N-1:0] omac_q, omac_d;
    logic         last_q, last_d;
    logic         active_q, active_d;
    logic         ok_q, ok_d;

    logic [N-1:0] rnd;
    logic [N-1:0] mac_next;
    logic [N-1:0] final_mac;
    logic         hold;

    assign rnd       = rotr1(s_q) ^ round_key(key_q, r_q);
    assign mac_next  = rotl1(mac_q ^ rnd);
    assign final_mac = mac_next ^ key_q;
    assign hold      = (state_q == StHold);

    // in_ready is forced low for as long as reset is held
    assign in_ready_o   = reset_n_i && (state_q == StIdle);
    assign out_valid_o  = hold;
    assign out_data_o   = hold ? s_q : '0;
    assign out_last_o   = hold && last_q;
    assign out_mac_o    = (hold && last_q) ? omac_q : '0;
    assign out_mac_ok_o = hold && last_q && ok_q;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        r_d      = r_q;
        key_d    = key_q;
        mac_d    = mac_q;
        tag_d    = tag_q;
        omac_d   = omac_q;
        last_d   = last_q;
        active_d = active_q;
        ok_d     = ok_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    s_d     = in_data_i;
                    last_d  = in_last_i;
                    r_d     = LastRound;
                    state_d = StRound;
                    if (in_last_i) tag_d = in_tag_i;
                    // key and MAC restart only on the first block of a message
                    if (!active_q) begin
                        key_d = in_key_i;
                        mac_d = '0;
                    end
                end
            end
            StRound: begin
                s_d = rnd;
                r_d = r_q - One;
                if (r_q == '0) begin
                    state_d = StHold;
                    mac_d   = mac_next;
                    omac_d  = last_q ? final_mac : '0;
                    ok_d    = last_q && (final_mac == tag_q);
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d  = StIdle;
                    active_d = !last_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            s_q      <= '0;
            r_q      <= '0;
            key_q    <= '0;
            mac_q    <= '0;
            tag_q    <= '0;
            omac_q   <= '0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            r_q      <= r_d;
            key_q    <= key_d;
            mac_q    <= mac_d;
            tag_q    <= tag_d;
            omac_q   <= omac_d;
            last_q   <= last_d;
            active_q <= active_d;
            ok_q     <= ok_d;
        end
    end

endmodule

// File: tb/tb_decrypt_mac_engine.sv
// Bench for decrypt_mac_engine: directed cases with literal expectations plus random
// multi-block messages checked every cycle against a queue-based reference model.
module tb_decrypt_mac_engine;

    localparam int unsigned N      = 8;
    localparam int unsigned ROUNDS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_key;
    logic [N-1:0] in_data;
    logic         in_last;
    logic [N-1:0] in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic [N-1:0] out_mac;
    logic         out_mac_ok;

    decrypt_mac_engine #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_key_i    (in_key),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_mac_o   (out_mac),
        .out_mac_ok_o(out_mac_ok)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int acc_cyc = 0;
    int rdy_pct = 100;
    bit force_lo = 1'b0;
    bit bp_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] m_rotl(input logic [N-1:0] x, input int k);
        for (int i = 0; i < k % N; i++) x = {x[N-2:0], x[N-1]};
        return x;
    endfunction

    function automatic logic [N-1:0] m_decrypt(input logic [N-1:0] key, input logic [N-1:0] c);
        logic [N-1:0] s;
        s = c;
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            s = {s[0], s[N-1:1]} ^ m_rotl(key, r) ^ N'(r);
        end
        return s;
    endfunction

    typedef struct {
        logic [N-1:0] data;
        logic         last;
        logic [N-1:0] mac;
        logic         ok;
        int           rdy;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    bit           m_active = 1'b0;
    logic [N-1:0] m_key;
    logic [N-1:0] m_mac;
    logic [N-1:0] m_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_mac", out_mac, 0);
            chk("rst_out_mac_ok", out_mac_ok, 0);
            q.delete();
            m_active = 1'b0;
        end else begin
            chk("in_ready", in_ready, q.size() == 0);
            chk("ready_valid_excl", in_ready && out_valid, 0);
            if (q.size() == 0) begin
                chk("out_valid_idle", out_valid, 0);
            end else begin
                e = q[0];
                chk("out_valid", out_valid, cyc >= e.rdy);
                if (out_valid) begin
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    chk("out_mac", out_mac, e.mac);
                    chk("out_mac_ok", out_mac_ok, e.ok);
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs_cyc = cyc + 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (!m_active) begin
                    m_key = in_key;
                    m_mac = '0;
                end
                m_p   = m_decrypt(m_key, in_data);
                m_mac = m_rotl(m_mac ^ m_p, 1);
                e.data = m_p;
                e.last = in_last;
                e.mac  = in_last ? (m_mac ^ m_key) : '0;
                e.ok   = in_last && ((m_mac ^ m_key) == in_tag);
                e.rdy  = cyc + 1 + ROUNDS;
                q.push_back(e);
                m_active = !in_last;
                acc_cyc  = cyc + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    always begin
        @(posedge clk);
        #1;
        out_ready = force_lo ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [N-1:0] k, input logic [N-1:0] d, input logic l,
                        input logic [N-1:0] t);
        int w;
        in_valid = 1'b1;
        in_key   = k;
        in_data  = d;
        in_last  = l;
        in_tag   = t;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; cnt counts negedges waited.
    task automatic wait_out(output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (out_valid) break;
            if (cnt > 200) begin
                chk("wait_out_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] d, input logic l,
                              input logic [N-1:0] m, input logic ok);
        int cnt;
        wait_out(cnt);
        chk({name, "_latency"}, cnt, ROUNDS + 1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_last"}, out_last, l);
        chk({name, "_mac"}, out_mac, m);
        chk({name, "_ok"}, out_mac_ok, ok);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int cnt;
        int nb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        in_data   = '0;
        in_last   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;

        chk("pin_model_zero", m_decrypt(8'h00, 8'h00), 8'h60);
        chk("pin_model_ff", m_decrypt(8'hFF, 8'hFF), 8'h9F);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(8'h00, 8'h00, 1'b1, 8'hC0);
        expect_out("single_ok", 8'h60, 1'b1, 8'hC0, 1'b1);
        send(8'h00, 8'h00, 1'b1, 8'hC1);
        expect_out("single_bad", 8'h60, 1'b1, 8'hC0, 1'b0);
        send(8'hFF, 8'hFF, 1'b1, 8'h00);
        expect_out("key_ff", 8'h9F, 1'b1, 8'hC0, 1'b0);
        send(8'h00, 8'h00, 1'b0, 8'h55);
        expect_out("two_blk1", 8'h60, 1'b0, 8'h00, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 8'h41);
        expect_out("two_blk2", 8'h60, 1'b1, 8'h41, 1'b1);

        // back-pressure with a block pending on the input side
        force_lo = 1'b1;
        send(8'h00, 8'h00, 1'b1, 8'hC0);
        wait_out(cnt);
        @(posedge clk);
        #1;
        fork
            begin
                send(8'h00, 8'h00, 1'b1, 8'hC0);
                bp_done = 1'b1;
            end
        join_none
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_data", out_data, 8'h60);
        end
        force_lo = 1'b0;
        cnt = 0;
        while (!bp_done && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_accept_done", bp_done, 1);
        chk("bp_accept_gap", acc_cyc - hs_cyc, 1);
        drain();
        @(posedge clk);
        #1;

        // reset mid-message, during round r=2 of the second block
        send(8'hAA, 8'h13, 1'b0, 8'h00);
        drain();
        @(posedge clk);
        #1;
        send(8'hAA, 8'h27, 1'b1, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_mac", out_mac, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h00, 8'h00, 1'b1, 8'hC0);
        expect_out("after_abort", 8'h60, 1'b1, 8'hC0, 1'b1);

        // random multi-block messages under random back-pressure
        rdy_pct = 60;
        for (int m = 0; m < 40; m++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                send(N'($urandom), N'($urandom), b == nb - 1, N'($urandom));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
